reduce_vector_loader: RTL and testbench

//   Upstream feeder for the reduce ALU. Collects a serial element stream into a

---
 rtl/reduce_vector_loader.sv | 141 ++++++++++++++
 tb/tb_reduce_vector_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_vector_loader.sv
// Serial-to-parallel vector loader for the reduce ALU: gathers up to N elements,
// pads short vectors with the op's neutral value, starts the ALU and returns its result.
module reduce_vector_loader #(
   parameter  int BITS = 8,
   parameter  int N    = 64,
   localparam int CW   = $clog2(N) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [BITS-1:0]          s_data,
   input  logic                     s_valid,
   input  logic                     s_last,
   input  logic [1:0]               s_sel,
   output logic                     s_ready,
   output logic [N-1:0][BITS-1:0]   vec_out,
   output logic [1:0]               sel_out,
   output logic                     set_out,
   output logic                     alu_en,
   input  logic                     alu_done,
   input  logic [BITS-1:0]          alu_result,
   output logic [BITS-1:0]          r_data,
   output logic [CW-1:0]            r_count,
   output logic                     r_valid,
   input  logic                     r_ready
);

   // state  | meaning
   // IDLE   | waiting for the first beat of a vector
   // LOAD   | collecting further beats into vec[idx]
   // PAD    | fill vec[idx..N-1] with the neutral value for sel_out
   // FIRE   | one-cycle set pulse to the ALU
   // WAIT   | ALU running; alu_done ignored in the first cycle
   // RESULT | result held on r_data until r_ready
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PAD,
      S_FIRE,
      S_WAIT,
      S_RESULT
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   idx;
   logic [CW-1:0]   idx_inc;
   logic            accept;
   logic            wait_first;
   logic [BITS-1:0] neutral;

   assign accept  = s_valid && s_ready;
   assign idx_inc = idx + CW'(1);

   always_comb begin
      neutral = '0;
      case (sel_out)
         2'b10:   neutral = {1'b0, {(BITS-1){1'b1}}};
         2'b11:   neutral = {1'b1, {(BITS-1){1'b0}}};
         default: neutral = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      s_ready  = 1'b0;
      set_out  = 1'b0;
      alu_en   = 1'b0;
      r_valid  = 1'b0;
      case (state)
         S_IDLE, S_LOAD: begin
            s_ready = 1'b1;
            if (accept) begin
               // the N-th beat ends the vector regardless of s_last
               if (idx_inc == CW'(N))
                  state_nx = S_FIRE;
               else if (s_last)
                  state_nx = S_PAD;
               else
                  state_nx = S_LOAD;
            end
         end
         S_PAD: begin
            state_nx = S_FIRE;
         end
         S_FIRE: begin
            set_out  = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            alu_en = 1'b1;
            if (!wait_first && alu_done)
               state_nx = S_RESULT;
         end
         S_RESULT: begin
            r_valid = 1'b1;
            if (r_ready)
               state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         sel_out    <= '0;
         wait_first <= 1'b0;
         r_data     <= '0;
         r_count    <= '0;
      end else begin
         state      <= state_nx;
         wait_first <= (state == S_FIRE);
         if (accept) begin
            if (state == S_IDLE)
               sel_out <= s_sel;
            idx <= idx_inc;
         end
         if (state == S_FIRE)
            r_count <= idx;
         if (state == S_WAIT && !wait_first && alu_done)
            r_data <= alu_result;
         if (state == S_RESULT && r_ready)
            idx <= '0;
      end
   end

   // stale elements beyond idx are always overwritten by PAD, so no clear on a new vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_out <= '0;
      end else begin
         for (int j = 0; j < N; j++) begin
            if (accept && idx == CW'(j))
               vec_out[j] <= s_data;
            else if (state == S_PAD && CW'(j) >= idx)
               vec_out[j] <= neutral;
         end
      end
   end

endmodule

// File: tb/tb_reduce_vector_loader.sv
// Directed bench for reduce_vector_loader with a behavioural reduce ALU that
// leaves alu_done high between operations.
module tb_reduce_vector_loader;
   localparam int BITS = 8;
   localparam int N    = 4;
   localparam int CW   = $clog2(N) + 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [BITS-1:0]        s_data;
   logic                   s_valid;
   logic                   s_last;
   logic [1:0]             s_sel;
   logic                   s_ready;
   logic [N-1:0][BITS-1:0] vec_out;
   logic [1:0]             sel_out;
   logic                   set_out;
   logic                   alu_en;
   logic                   alu_done;
   logic [BITS-1:0]        alu_result;
   logic [BITS-1:0]        r_data;
   logic [CW-1:0]          r_count;
   logic                   r_valid;
   logic                   r_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reduce_vector_loader #(.BITS(BITS), .N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_last     (s_last),
      .s_sel      (s_sel),
      .s_ready    (s_ready),
      .vec_out    (vec_out),
      .sel_out    (sel_out),
      .set_out    (set_out),
      .alu_en     (alu_en),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .r_data     (r_data),
      .r_count    (r_count),
      .r_valid    (r_valid),
      .r_ready    (r_ready)
   );

   typedef struct {
      int                     nb;
      bit                     last;
      logic [1:0]             sel;
      logic [N-1:0][BITS-1:0] d;
      logic [N-1:0][BITS-1:0] e;
      logic [BITS-1:0]        r;
      int                     cnt;
      int                     hold;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int nb, input bit last, input logic [1:0] sel,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3,
                               input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3,
                               input logic [7:0] r, input int cnt, input int hold);
      vec_t v;
      v.nb = nb; v.last = last; v.sel = sel;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
      v.e[0] = e0; v.e[1] = e1; v.e[2] = e2; v.e[3] = e3;
      v.r = r; v.cnt = cnt; v.hold = hold;
      return v;
   endfunction

   function automatic logic [7:0] alu_calc(input logic [N-1:0][BITS-1:0] v, input logic [1:0] s);
      logic [7:0] acc;
      acc = v[0];
      for (int k = 1; k < N; k++) begin
         case (s)
            2'b00: acc = acc + v[k];
            2'b01: acc = acc | v[k];
            2'b10: if ($signed(v[k]) < $signed(acc)) acc = v[k];
            default: if ($signed(v[k]) > $signed(acc)) acc = v[k];
         endcase
      end
      return acc;
   endfunction

   // ALU model: result appears three cycles after set; done stays high afterwards,
   // so every later op starts with a stale done/result in its first WAIT cycle.
   initial begin
      logic [7:0] res;
      alu_done   = 1'b0;
      alu_result = '0;
      forever begin
         @(negedge clk);
         if (set_out === 1'b1) begin
            res = alu_calc(vec_out, sel_out);
            @(negedge clk);
            @(negedge clk);
            alu_done = 1'b0;
            @(negedge clk);
            alu_result = res;
            alu_done   = 1'b1;
         end
      end
   end

   task automatic run(input vec_t v);
      int lat;
      int w;
      for (int i = 0; i < v.nb; i++) begin
         @(negedge clk);
         chk("s_ready_load", {31'd0, s_ready}, 32'd1);
         s_valid = 1'b1;
         s_data  = v.d[i];
         s_sel   = (i == 0) ? v.sel : ~v.sel;
         s_last  = v.last && (i == v.nb - 1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      lat = 1;
      while (!set_out && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk("set_latency", lat, (v.nb == N) ? 32'd1 : 32'd2);
      chk("vec_out", vec_out, v.e);
      chk("sel_out", {30'd0, sel_out}, {30'd0, v.sel});
      chk("s_ready_fire", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
      chk("set_pulse", {31'd0, set_out}, 32'd0);
      w = 0;
      while (!r_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("r_valid", {31'd0, r_valid}, 32'd1);
      chk("r_data", {24'd0, r_data}, {24'd0, v.r});
      chk("r_count", {29'd0, r_count}, v.cnt);
      chk("s_ready_result", {31'd0, s_ready}, 32'd0);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge clk);
         chk("hold_valid", {31'd0, r_valid}, 32'd1);
         chk("hold_data", {24'd0, r_data}, {24'd0, v.r});
         chk("hold_s_ready", {31'd0, s_ready}, 32'd0);
      end
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      chk("r_valid_clear", {31'd0, r_valid}, 32'd0);
      chk("s_ready_idle", {31'd0, s_ready}, 32'd1);
   endtask

   vec_t tv[6];

   initial begin
      int w;
      tv[0] = mk(4, 0, 2'b00, 8'd1, 8'd2, 8'd3, 8'd4,
                 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 4, 0);
      tv[1] = mk(2, 1, 2'b11, 8'hFB, 8'd7, 8'd0, 8'd0,
                 8'hFB, 8'd7, 8'h80, 8'h80, 8'd7, 2, 5);
      tv[2] = mk(1, 1, 2'b10, 8'd3, 8'd0, 8'd0, 8'd0,
                 8'd3, 8'h7F, 8'h7F, 8'h7F, 8'd3, 1, 0);
      tv[3] = mk(4, 1, 2'b01, 8'd1, 8'd2, 8'd4, 8'd8,
                 8'd1, 8'd2, 8'd4, 8'd8, 8'd15, 4, 0);
      tv[4] = mk(3, 1, 2'b10, 8'hFD, 8'hF7, 8'd5, 8'd0,
                 8'hFD, 8'hF7, 8'd5, 8'h7F, 8'hF7, 3, 0);
      tv[5] = mk(3, 1, 2'b00, 8'd100, 8'd100, 8'd100, 8'd0,
                 8'd100, 8'd100, 8'd100, 8'd0, 8'h2C, 3, 0);

      rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_sel = '0; r_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_vec", vec_out, 32'd0);
      chk("rst_sel", {30'd0, sel_out}, 32'd0);
      chk("rst_set", {31'd0, set_out}, 32'd0);
      chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
      chk("rst_r_data", {24'd0, r_data}, 32'd0);
      chk("rst_r_count", {29'd0, r_count}, 32'd0);
      chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++) run(tv[t]);

      // reset while the ALU is running
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         s_valid = 1'b1; s_data = 8'(5 + i); s_sel = 2'b00; s_last = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b0;
      w = 0;
      while (!alu_en && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("wait_reached", {31'd0, alu_en}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vec", vec_out, 32'd0);
      chk("mid_rst_sel", {30'd0, sel_out}, 32'd0);
      chk("mid_rst_alu_en", {31'd0, alu_en}, 32'd0);
      chk("mid_rst_r_data", {24'd0, r_data}, 32'd0);
      chk("mid_rst_r_count", {29'd0, r_count}, 32'd0);
      chk("mid_rst_r_valid", {31'd0, r_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(mk(4, 0, 2'b00, 8'd1, 8'd1, 8'd1, 8'd1,
             8'd1, 8'd1, 8'd1, 8'd1, 8'd4, 4, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
